// File: rtl/alu_dispatch.sv
// Two-stage issue unit: stage 1 drives ALU operands/control, stage 2 captures the ALU result.
// Define ALU_DISPATCH_BRANCH_EN to decode BRANCH opcodes and resolve branch_taken.
module alu_dispatch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [3:0]  ALUControl,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic        Sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        illegal
);

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSrl  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1111;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {KindAlu, KindBranch, KindIllegal} kind_e;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_ctl;
  kind_e       dec_kind;

  always_comb begin
    dec_kind = KindIllegal;
    dec_a    = '0;
    dec_b    = '0;
    dec_ctl  = AluAdd;
    case (opcode)
      OpcOp: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        if (funct7 == 7'b0000000) begin
          dec_kind = KindAlu;
          case (funct3)
            3'b000:  dec_ctl = AluAdd;
            3'b001:  dec_ctl = AluSll;
            3'b010:  dec_ctl = AluSlt;
            3'b011:  dec_ctl = AluSltu;
            3'b100:  dec_ctl = AluXor;
            3'b101:  dec_ctl = AluSrl;
            3'b110:  dec_ctl = AluOr;
            default: dec_ctl = AluAnd;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_kind = KindAlu;
          dec_ctl  = AluSub;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_kind = KindAlu;
          dec_ctl  = AluSra;
        end
      end
      OpcOpImm: begin
        dec_a = rs1_val;
        dec_b = imm;
        case (funct3)
          3'b000: dec_kind = KindAlu;
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              dec_kind = KindAlu;
              dec_ctl  = AluSll;
            end
          end
          3'b101: begin
            if (funct7 == 7'b0000000) begin
              dec_kind = KindAlu;
              dec_ctl  = AluSrl;
            end else if (funct7 == 7'b0100000) begin
              dec_kind = KindAlu;
              dec_ctl  = AluSra;
            end
          end
          default: ;
        endcase
      end
      OpcLui: begin
        dec_kind = KindAlu;
        dec_b    = imm;
      end
      OpcAuipc: begin
        dec_kind = KindAlu;
        dec_a    = pc;
        dec_b    = imm;
      end
`ifdef ALU_DISPATCH_BRANCH_EN
      OpcBranch: begin
        dec_a = rs1_val;
        dec_b = rs2_val;
        case (funct3)
          3'b000, 3'b001: begin dec_kind = KindBranch; dec_ctl = AluSub;  end
          3'b100, 3'b101: begin dec_kind = KindBranch; dec_ctl = AluSlt;  end
          3'b110, 3'b111: begin dec_kind = KindBranch; dec_ctl = AluSltu; end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase
    // Shift amounts are clamped so the ALU never sees more than 31.
    if (dec_ctl == AluSll || dec_ctl == AluSrl || dec_ctl == AluSra) begin
      dec_b = {27'b0, dec_b[4:0]};
    end
    if (dec_kind == KindIllegal) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_ctl = AluAdd;
    end
  end

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] srca_q, srca_d, srcb_q, srcb_d;
  logic [3:0]  ctl_q, ctl_d;
  kind_e       kind_q, kind_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;
  logic        s2_adv, accept, s2_taken;

  assign s2_adv   = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign accept   = in_valid & in_ready;

`ifdef ALU_DISPATCH_BRANCH_EN
  always_comb begin
    s2_taken = 1'b0;
    if (kind_q == KindBranch) begin
      case (funct3_q)
        3'b000:         s2_taken = Zero;
        3'b001:         s2_taken = ~Zero;
        3'b100, 3'b110: s2_taken = ALUResult[0];
        3'b101, 3'b111: s2_taken = ~ALUResult[0];
        default:        s2_taken = 1'b0;
      endcase
    end
  end
`else
  assign s2_taken = 1'b0;
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    ctl_d       = ctl_q;
    kind_d      = kind_q;
    funct3_d    = funct3_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    if (in_ready) s1_valid_d = in_valid;
    if (accept) begin
      srca_d   = dec_a;
      srcb_d   = dec_b;
      ctl_d    = dec_ctl;
      kind_d   = dec_kind;
      funct3_d = funct3;
    end
    // Payload only loads from a valid stage 1 so an empty slot leaves it untouched.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d  = (kind_q == KindAlu) ? ALUResult : 32'h0;
        taken_d   = s2_taken;
        illegal_d = (kind_q == KindIllegal);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      srca_q      <= '0;
      srcb_q      <= '0;
      ctl_q       <= AluAdd;
      kind_q      <= KindAlu;
      funct3_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
      ctl_q       <= ctl_d;
      kind_q      <= kind_d;
      funct3_q    <= funct3_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign SrcA         = srca_q;
  assign SrcB         = srcb_q;
  assign ALUControl   = ctl_q;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;

  logic unused_sig;
  assign unused_sig = ^{Sign, instr[24:15], instr[11:7], Zero, funct3_q};

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: behavioural ALU, instruction-level reference model and scoreboard.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] instr, pc, rs1_val, rs2_val, imm;
  logic [31:0] SrcA, SrcB, ALUResult, result;
  logic [3:0]  ALUControl;
  logic        Zero, Sign, out_valid, out_ready, branch_taken, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  alu_dispatch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero), .Sign(Sign),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // External ALU between the two stages.
  always_comb begin
    case (ALUControl)
      4'b0000: ALUResult = SrcA + SrcB;
      4'b0001: ALUResult = SrcA - SrcB;
      4'b0010: ALUResult = SrcA & SrcB;
      4'b0011: ALUResult = SrcA | SrcB;
      4'b0100: ALUResult = SrcA << SrcB[4:0];
      4'b0101: ALUResult = {31'b0, $signed(SrcA) < $signed(SrcB)};
      4'b0110: ALUResult = SrcA ^ SrcB;
      4'b0111: ALUResult = SrcA >> SrcB[4:0];
      4'b1000: ALUResult = {31'b0, SrcA < SrcB};
      4'b1111: ALUResult = $signed(SrcA) >>> SrcB[4:0];
      default: ALUResult = 32'h0;
    endcase
    Zero = (ALUResult == 32'h0);
    Sign = ALUResult[31];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
    return {f7, 10'b0, f3, 5'b0, op};
  endfunction

  // Reference: {illegal, taken, result} from instruction semantics.
  function automatic logic [33:0] model(input logic [31:0] i, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] m);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    logic [31:0] r = 32'h0;
    logic tk = 1'b0;
    logic il = 1'b0;
    case (op)
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: r = a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> b[4:0];
        else il = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd0) r = a + m;
        else if (f3 == 3'd1 && f7 == 7'h00) r = a << m[4:0];
        else if (f3 == 3'd5 && f7 == 7'h00) r = a >> m[4:0];
        else if (f3 == 3'd5 && f7 == 7'h20) r = $signed(a) >>> m[4:0];
        else il = 1'b1;
      end
      7'h37: r = m;
      7'h17: r = p + m;
`ifdef ALU_DISPATCH_BRANCH_EN
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: il = 1'b1;
        endcase
      end
`endif
      default: il = 1'b1;
    endcase
    if (il) r = 32'h0;
    return {il, tk, r};
  endfunction

  logic [33:0] exp_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check(out_ready ? "result" : "hold_result", result, exp_q[0][31:0]);
          check(out_ready ? "taken" : "hold_taken", {31'b0, branch_taken}, {31'b0, exp_q[0][32]});
          check(out_ready ? "illegal" : "hold_illegal", {31'b0, illegal}, {31'b0, exp_q[0][33]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(instr, pc, rs1_val, rs2_val, imm));
    end
  end

  task automatic set_pkt(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] m);
    instr = i; pc = p; rs1_val = a; rs2_val = b; imm = m;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] m);
    bit ok = 1'b0;
    set_pkt(i, p, a, b, m);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Pipe empty and out_ready=1: checks the packet two edges after acceptance.
  task automatic send_expect(input string tag, input logic [31:0] i, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] m,
                             input logic [31:0] er, input logic et, input logic ei);
    send(i, 32'h0, a, b, m);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_result"}, result, er);
    check({tag, "_taken"}, {31'b0, branch_taken}, {31'b0, et});
    check({tag, "_illegal"}, {31'b0, illegal}, {31'b0, ei});
    @(posedge clk); #1;
  endtask

  task automatic rand_pkt();
    logic [31:0] a = $urandom();
    logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom();
    logic [31:0] m = $urandom();
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    logic [2:0]  imm_f3 [3] = '{3'd0, 3'd1, 3'd5};
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] i;
    case ($urandom_range(0, 9))
      0, 1: i = enc(7'h33, f3, 7'h00);
      2:    i = enc(7'h33, $urandom_range(0, 1) ? 3'd5 : 3'd0, 7'h20);
      3: begin
        f3 = imm_f3[$urandom_range(0, 2)];
        i = enc(7'h13, f3, (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      end
      4:    i = enc(7'h37, 3'($urandom), 7'($urandom));
      5:    i = enc(7'h17, 3'($urandom), 7'($urandom));
      6:    i = enc(7'h63, br_f3[$urandom_range(0, 5)], 7'h00);
      7:    i = enc(7'h33, f3, 7'($urandom));
      8:    i = enc(7'h7F, f3, 7'h00);
      default: i = enc(7'h13, 3'd1, 7'h20);
    endcase
    set_pkt(i, $urandom(), a, b, m);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_pkt(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_srcs", SrcA | SrcB, 32'd0);
    check("rst_ctl", {28'b0, ALUControl}, 32'd0);
    check("rst_payload", {result[31:2], result[1:0] | {branch_taken, illegal}}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back add, sub, sra.
    set_pkt(enc(7'h33, 3'd0, 7'h00), 32'h0, 32'd5, 32'd7, 32'h0);
    in_valid = 1'b1;
    @(negedge clk);
    check("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_pkt(enc(7'h33, 3'd0, 7'h20), 32'h0, 32'd5, 32'd7, 32'h0);
    @(negedge clk);
    check("b2b_latency", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    set_pkt(enc(7'h33, 3'd5, 7'h20), 32'h0, 32'h80000000, 32'd4, 32'h0);
    @(negedge clk);
    check("b2b_add", result, 32'd12);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_sub", result, 32'hFFFFFFFE);
    @(negedge clk);
    check("b2b_sra", result, 32'hF8000000);
    @(posedge clk); #1;

    // slli clamps the shift amount; funct7=0100000 with funct3=001 is illegal.
    send(enc(7'h13, 3'd1, 7'h00), 32'h0, 32'd1, 32'h0, 32'h25);
    @(negedge clk);
    check("slli_srcb", SrcB, 32'd5);
    @(negedge clk);
    check("slli_result", result, 32'h20);
    @(posedge clk); #1;
    send(enc(7'h13, 3'd1, 7'h20), 32'h0, 32'd9, 32'h0, 32'h3);
    @(negedge clk);
    check("ill_srcs", SrcA | SrcB | {28'b0, ALUControl}, 32'd0);
    @(posedge clk); #1;
    send_expect("ill_slli", enc(7'h13, 3'd1, 7'h20), 32'd9, 32'd0, 32'd3, 32'd0, 1'b0, 1'b1);

    send_expect("lui", enc(7'h37, 3'd0, 7'h00), 32'd1, 32'd2, 32'h12345000, 32'h12345000,
                1'b0, 1'b0);
    set_pkt(32'h0, 32'h100, 32'h0, 32'h0, 32'h0);
    send(enc(7'h17, 3'd0, 7'h00), 32'h100, 32'd7, 32'd7, 32'h1000);
    @(negedge clk);
    @(negedge clk);
    check("auipc", result, 32'h1100);
    @(posedge clk); #1;
    send_expect("opc_7f", enc(7'h7F, 3'd0, 7'h00), 32'd1, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
`ifdef ALU_DISPATCH_BRANCH_EN
    send_expect("blt", enc(7'h63, 3'd4, 7'h00), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    send_expect("bltu", enc(7'h63, 3'd6, 7'h00), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    send_expect("bne", enc(7'h63, 3'd1, 7'h00), 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    send_expect("beq", enc(7'h63, 3'd0, 7'h00), 32'd3, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0);
`else
    send_expect("beq_off", enc(7'h63, 3'd0, 7'h00), 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1);
`endif

    // Stall: xor, add(5,7), or offered with out_ready low.
    out_ready = 1'b0;
    send(enc(7'h33, 3'd4, 7'h00), 32'h0, 32'hF0F0, 32'h0FF0, 32'h0);
    send(enc(7'h33, 3'd0, 7'h00), 32'h0, 32'd5, 32'd7, 32'h0);
    set_pkt(enc(7'h33, 3'd6, 7'h00), 32'h0, 32'h1, 32'h2, 32'h0);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_srca", SrcA, 32'd5);
      check("stall_srcb", SrcB, 32'd7);
      check("stall_ctl", {28'b0, ALUControl}, 32'd0);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stall_drained", exp_q.size(), 32'd0);

    // Reset with two packets in flight.
    out_ready = 1'b0;
    send(enc(7'h33, 3'd0, 7'h00), 32'h0, 32'd11, 32'd22, 32'h0);
    send(enc(7'h13, 3'd0, 7'h00), 32'h0, 32'd33, 32'h0, 32'd44);
    reset = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("midrst_srcs", SrcA | SrcB | {28'b0, ALUControl}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_no_stale", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure; the scoreboard checks every packet.
    begin
      int sent = 0;
      bit fire;
      for (int c = 0; c < 4000 && sent < 400; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid && $urandom_range(0, 3) != 0) begin
          rand_pkt();
          in_valid = 1'b1;
        end
        @(negedge clk);
        fire = in_valid && in_ready;
        @(posedge clk); #1;
        if (fire) begin
          in_valid = 1'b0;
          sent++;
        end
      end
      check("rand_sent", sent, 32'd400);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("final_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
